// File: rtl/r2w1_write_merger.sv
// Write-side front end for the 2R/1W register RAM: merges two valid/ready write
// channels through a small in-order FIFO onto the RAM's single registered write port.
module r2w1_write_merger #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  valid_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic                  ready_a,
  input  logic                  valid_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  ready_b,
  output logic [ADDR_WIDTH-1:0] addr_w,
  output logic [DATA_WIDTH-1:0] data_w,
  output logic                  we,
  output logic                  busy
);

  localparam int DEPTH = 2 ** DEPTH_BITS;
  localparam int CW    = DEPTH_BITS + 1;
  localparam int EW    = ADDR_WIDTH + DATA_WIDTH;

  logic [EW-1:0]         mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wrPtr_q, wrPtr_d;
  logic [DEPTH_BITS-1:0] rdPtr_q, rdPtr_d;
  logic [DEPTH_BITS-1:0] wrPtrNext;
  logic [DEPTH_BITS-1:0] slotB;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] addrW_q, addrW_d;
  logic [DATA_WIDTH-1:0] dataW_q, dataW_d;
  logic                  we_q, we_d;
  logic                  accA, accB, pop;

  // Readies come from the registered count only, so producers see no path from the drain.
  assign ready_a = (count_q <= CW'(DEPTH - 1));
  assign ready_b = (count_q <= CW'(DEPTH - 2));

  assign accA      = valid_a & ready_a;
  assign accB      = valid_b & ready_b;
  assign pop       = (count_q != '0);
  assign wrPtrNext = wrPtr_q + DEPTH_BITS'(1);
  assign slotB     = accA ? wrPtrNext : wrPtr_q;

  always_comb begin
    wrPtr_d = wrPtr_q + DEPTH_BITS'(accA) + DEPTH_BITS'(accB);
    rdPtr_d = rdPtr_q;
    count_d = count_q + CW'(accA) + CW'(accB) - CW'(pop);
    addrW_d = addrW_q;
    dataW_d = dataW_q;
    we_d    = pop;
    if (pop) begin
      rdPtr_d = rdPtr_q + DEPTH_BITS'(1);
      {addrW_d, dataW_d} = mem_q[rdPtr_q];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      addrW_q <= '0;
      dataW_q <= '0;
      we_q    <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      addrW_q <= addrW_d;
      dataW_q <= dataW_d;
      we_q    <= we_d;
    end
  end

  // B lands behind A, so for a shared address B's data is issued last and wins.
  always_ff @(posedge clk) begin
    if (accA) mem_q[wrPtr_q] <= {addr_a, data_a};
    if (accB) mem_q[slotB]   <= {addr_b, data_b};
  end

  assign addr_w = addrW_q;
  assign data_w = dataW_q;
  assign we     = we_q;
  assign busy   = (count_q != '0) | we_q;

endmodule

// File: tb/tb_r2w1_write_merger.sv
// Directed self-checking bench for r2w1_write_merger (default DEPTH = 4).
module tb_r2w1_write_merger;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_a, valid_b;
  logic [11:0] addr_a, addr_b;
  logic [7:0]  data_a, data_b;
  logic        ready_a, ready_b;
  logic [11:0] addr_w;
  logic [7:0]  data_w;
  logic        we, busy;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] ramModel [4096];

  r2w1_write_merger dut (
    .clk(clk), .reset_n(reset_n),
    .valid_a(valid_a), .addr_a(addr_a), .data_a(data_a), .ready_a(ready_a),
    .valid_b(valid_b), .addr_b(addr_b), .data_b(data_b), .ready_b(ready_b),
    .addr_w(addr_w), .data_w(data_w), .we(we), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behaves like the RAM behind the write port.
  always @(posedge clk) if (we) ramModel[addr_w] <= data_w;

  task automatic applyStimulus(input logic va, input logic [11:0] aa, input logic [7:0] da,
                               input logic vb, input logic [11:0] ab, input logic [7:0] db);
    valid_a = va; addr_a = aa; data_a = da;
    valid_b = vb; addr_b = ab; data_b = db;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] expIssue [10];
    expIssue = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd14};
    for (int i = 0; i < 4096; i++) ramModel[i] = 8'h00;

    reset_n = 1'b0;
    applyStimulus(1'b0, 12'h0, 8'h0, 1'b0, 12'h0, 8'h0);
    #12;
    checkOutput("rst_we", 32'(we), 32'd0);
    checkOutput("rst_addr_w", 32'(addr_w), 32'd0);
    checkOutput("rst_data_w", 32'(data_w), 32'd0);
    checkOutput("rst_ready_a", 32'(ready_a), 32'd1);
    checkOutput("rst_ready_b", 32'(ready_b), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    stepClock();

    $display("[TB] single A write");
    applyStimulus(1'b1, 12'h010, 8'h5A, 1'b0, 12'h0, 8'h0);
    stepClock();
    applyStimulus(1'b0, 12'h0, 8'h0, 1'b0, 12'h0, 8'h0);
    checkOutput("t1_we_early", 32'(we), 32'd0);
    checkOutput("t1_busy_queued", 32'(busy), 32'd1);
    stepClock();
    checkOutput("t1_we", 32'(we), 32'd1);
    checkOutput("t1_addr_w", 32'(addr_w), 32'h010);
    checkOutput("t1_data_w", 32'(data_w), 32'h5A);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    stepClock();
    checkOutput("t1_we_off", 32'(we), 32'd0);
    checkOutput("t1_busy_off", 32'(busy), 32'd0);
    checkOutput("t1_data_hold", 32'(data_w), 32'h5A);

    $display("[TB] same-address A+B");
    applyStimulus(1'b1, 12'h020, 8'h11, 1'b1, 12'h020, 8'h22);
    stepClock();
    applyStimulus(1'b0, 12'h0, 8'h0, 1'b0, 12'h0, 8'h0);
    stepClock();
    checkOutput("t2_we0", 32'(we), 32'd1);
    checkOutput("t2_data0", 32'(data_w), 32'h11);
    stepClock();
    checkOutput("t2_we1", 32'(we), 32'd1);
    checkOutput("t2_addr1", 32'(addr_w), 32'h020);
    checkOutput("t2_data1", 32'(data_w), 32'h22);
    stepClock();
    checkOutput("t2_we_off", 32'(we), 32'd0);
    checkOutput("t2_ram", 32'(ramModel[12'h020]), 32'h22);

    $display("[TB] both channels saturated");
    for (int k = 1; k <= 12; k++) begin
      if (k <= 8) begin
        applyStimulus(1'b1, 12'h100 + 12'(2*(k-1)), 8'(2*(k-1)),
                      1'b1, 12'h100 + 12'(2*(k-1)+1), 8'(2*(k-1)+1));
        checkOutput($sformatf("t3_ready_a_%0d", k), 32'(ready_a), 32'd1);
        checkOutput($sformatf("t3_ready_b_%0d", k), 32'(ready_b), (k <= 2) ? 32'd1 : 32'd0);
      end else begin
        applyStimulus(1'b0, 12'h0, 8'h0, 1'b0, 12'h0, 8'h0);
      end
      stepClock();
      if (k >= 2 && k <= 11) begin
        checkOutput($sformatf("t3_we_%0d", k), 32'(we), 32'd1);
        checkOutput($sformatf("t3_data_%0d", k), 32'(data_w), 32'(expIssue[k-2]));
        checkOutput($sformatf("t3_addr_%0d", k), 32'(addr_w), 32'h100 + 32'(expIssue[k-2]));
      end
    end
    checkOutput("t3_we_end", 32'(we), 32'd0);
    checkOutput("t3_busy_end", 32'(busy), 32'd0);

    $display("[TB] pointer wrap with A only");
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) applyStimulus(1'b1, 12'h200 + 12'(k), 8'(k), 1'b0, 12'h0, 8'h0);
      else        applyStimulus(1'b0, 12'h0, 8'h0, 1'b0, 12'h0, 8'h0);
      stepClock();
      if (k >= 1) begin
        checkOutput($sformatf("t4_we_%0d", k), 32'(we), 32'd1);
        checkOutput($sformatf("t4_data_%0d", k), 32'(data_w), 32'(k-1));
      end
    end
    stepClock();
    checkOutput("t4_we_end", 32'(we), 32'd0);
    checkOutput("t4_busy_end", 32'(busy), 32'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 12'h300, 8'hA0, 1'b1, 12'h301, 8'hA1);
    stepClock();
    applyStimulus(1'b1, 12'h302, 8'hA2, 1'b1, 12'h303, 8'hA3);
    stepClock();
    applyStimulus(1'b0, 12'h0, 8'h0, 1'b0, 12'h0, 8'h0);
    checkOutput("t5_we_before", 32'(we), 32'd1);
    checkOutput("t5_ready_b_full", 32'(ready_b), 32'd0);
    reset_n = 1'b0;
    #1;
    checkOutput("t5_we_async", 32'(we), 32'd0);
    checkOutput("t5_busy_async", 32'(busy), 32'd0);
    #2;
    reset_n = 1'b1;
    checkOutput("t5_ready_a", 32'(ready_a), 32'd1);
    checkOutput("t5_ready_b", 32'(ready_b), 32'd1);
    for (int k = 0; k < 4; k++) begin
      stepClock();
      checkOutput($sformatf("t5_no_write_%0d", k), 32'(we), 32'd0);
    end

    $display("[TB] B only stream");
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) begin
        applyStimulus(1'b0, 12'h0, 8'h0, 1'b1, 12'h400 + 12'(k), 8'h30 + 8'(k));
        checkOutput($sformatf("t6_ready_a_%0d", k), 32'(ready_a), 32'd1);
        checkOutput($sformatf("t6_ready_b_%0d", k), 32'(ready_b), 32'd1);
      end else begin
        applyStimulus(1'b0, 12'h0, 8'h0, 1'b0, 12'h0, 8'h0);
      end
      stepClock();
      if (k >= 1) begin
        checkOutput($sformatf("t6_we_%0d", k), 32'(we), 32'd1);
        checkOutput($sformatf("t6_data_%0d", k), 32'(data_w), 32'h30 + 32'(k-1));
      end
    end
    stepClock();
    checkOutput("t6_we_end", 32'(we), 32'd0);
    checkOutput("t6_busy_end", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
